// File: rtl/decode_stage.sv
// decode_stage: combinational RV32I (+ optional RV32M) decoder feeding a 1- or 2-entry
// output buffer; both sides use valid/ready handshakes.
module decode_stage #(
    parameter int ENABLE_M     = 0,
    parameter int BUF_DEPTH    = 2,
    parameter int ZERO_RD_NOWE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_ir,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  srcreg1_num,
    output logic [4:0]  srcreg2_num,
    output logic [4:0]  dstreg_num,
    output logic [31:0] imm,
    output logic [5:0]  alucode,
    output logic [1:0]  aluop1_type,
    output logic [1:0]  aluop2_type,
    output logic        reg_we,
    output logic        is_load,
    output logic        is_store,
    output logic        illegal,
    output logic [1:0]  o_dbg_count
);

    localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
    localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
    localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
    localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
    localparam logic [5:0] ALU_SUB  = 6'd18, ALU_XOR  = 6'd19, ALU_OR   = 6'd20;
    localparam logic [5:0] ALU_AND  = 6'd21, ALU_SLL  = 6'd22, ALU_SRL  = 6'd23;
    localparam logic [5:0] ALU_SRA  = 6'd24, ALU_SLT  = 6'd25, ALU_SLTU = 6'd26;
    localparam logic [5:0] ALU_MUL  = 6'd27;
    localparam logic [5:0] ALU_NOP  = 6'd63;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

    localparam logic [6:0] OPC_OP      = 7'h33, OPC_OPIMM  = 7'h13, OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC   = 7'h17, OPC_JAL    = 7'h6F, OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH  = 7'h63, OPC_LOAD   = 7'h03, OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73, OPC_MISCMEM = 7'h0F;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [5:0]  alucode;
        logic [1:0]  op1_type;
        logic [1:0]  op2_type;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [5:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic        w_legal;
    logic        w_writes_rd;
    entry_t      w_dec;

    assign w_opcode = in_ir[6:0];
    assign w_funct3 = in_ir[14:12];
    assign w_funct7 = in_ir[31:25];
    assign w_rd     = in_ir[11:7];
    assign w_rs1    = in_ir[19:15];
    assign w_rs2    = in_ir[24:20];
    assign w_imm_i  = {{20{in_ir[31]}}, in_ir[31:20]};
    assign w_imm_s  = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
    assign w_imm_b  = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    assign w_imm_u  = {in_ir[31:12], 12'd0};
    assign w_imm_j  = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
    // Shift-immediates carry only the shift amount, not the funct7 bits.
    assign w_imm_sh = {27'd0, in_ir[24:20]};

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.alucode = ALU_NOP;
        w_legal       = (in_ir[1:0] == 2'b11);
        w_writes_rd   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_dec.src1     = w_rs1;
                w_dec.src2     = w_rs2;
                w_dec.dst      = w_rd;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_REG;
                w_writes_rd    = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_dec.alucode = base_alu(w_funct3, 1'b0);
                end else if (w_funct7 == 7'b0100000 && (w_funct3 == 3'd0 || w_funct3 == 3'd5)) begin
                    w_dec.alucode = base_alu(w_funct3, 1'b1);
                end else if (w_funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    w_dec.alucode = ALU_MUL + {3'b000, w_funct3};
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                w_dec.src1     = w_rs1;
                w_dec.dst      = w_rd;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_IMM;
                w_writes_rd    = 1'b1;
                if (w_funct3 == 3'd1) begin
                    w_dec.imm     = w_imm_sh;
                    w_dec.alucode = ALU_SLL;
                    w_legal       = w_legal && (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'd5) begin
                    w_dec.imm     = w_imm_sh;
                    w_dec.alucode = base_alu(3'd5, w_funct7[5]);
                    w_legal       = w_legal && (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
                end else begin
                    w_dec.imm     = w_imm_i;
                    w_dec.alucode = base_alu(w_funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                w_dec.dst      = w_rd;
                w_dec.imm      = w_imm_u;
                w_dec.alucode  = ALU_LUI;
                w_dec.op1_type = OP_TYPE_NONE;
                w_dec.op2_type = OP_TYPE_IMM;
                w_writes_rd    = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.dst      = w_rd;
                w_dec.imm      = w_imm_u;
                w_dec.alucode  = ALU_ADD;
                w_dec.op1_type = OP_TYPE_PC;
                w_dec.op2_type = OP_TYPE_IMM;
                w_writes_rd    = 1'b1;
            end
            OPC_JAL: begin
                w_dec.dst      = w_rd;
                w_dec.imm      = w_imm_j;
                w_dec.alucode  = ALU_JAL;
                w_dec.op1_type = OP_TYPE_PC;
                w_dec.op2_type = OP_TYPE_IMM;
                w_writes_rd    = 1'b1;
            end
            OPC_JALR: begin
                w_dec.src1     = w_rs1;
                w_dec.dst      = w_rd;
                w_dec.imm      = w_imm_i;
                w_dec.alucode  = ALU_JALR;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_IMM;
                w_writes_rd    = 1'b1;
                w_legal        = w_legal && (w_funct3 == 3'd0);
            end
            OPC_BRANCH: begin
                w_dec.src1     = w_rs1;
                w_dec.src2     = w_rs2;
                w_dec.imm      = w_imm_b;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_REG;
                case (w_funct3)
                    3'd0:    w_dec.alucode = ALU_BEQ;
                    3'd1:    w_dec.alucode = ALU_BNE;
                    3'd4:    w_dec.alucode = ALU_BLT;
                    3'd5:    w_dec.alucode = ALU_BGE;
                    3'd6:    w_dec.alucode = ALU_BLTU;
                    3'd7:    w_dec.alucode = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                w_dec.src1     = w_rs1;
                w_dec.dst      = w_rd;
                w_dec.imm      = w_imm_i;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_IMM;
                w_dec.is_load  = 1'b1;
                w_writes_rd    = 1'b1;
                case (w_funct3)
                    3'd0:    w_dec.alucode = ALU_LB;
                    3'd1:    w_dec.alucode = ALU_LH;
                    3'd2:    w_dec.alucode = ALU_LW;
                    3'd4:    w_dec.alucode = ALU_LBU;
                    3'd5:    w_dec.alucode = ALU_LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_dec.src1     = w_rs1;
                w_dec.src2     = w_rs2;
                w_dec.imm      = w_imm_s;
                w_dec.op1_type = OP_TYPE_REG;
                w_dec.op2_type = OP_TYPE_REG;
                w_dec.is_store = 1'b1;
                case (w_funct3)
                    3'd0:    w_dec.alucode = ALU_SB;
                    3'd1:    w_dec.alucode = ALU_SH;
                    3'd2:    w_dec.alucode = ALU_SW;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_SYSTEM, OPC_MISCMEM: begin
                w_dec.alucode = ALU_NOP;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.pc      = in_pc;
            w_dec.alucode = ALU_NOP;
            w_dec.illegal = 1'b1;
        end else begin
            w_dec.reg_we = w_writes_rd && (ZERO_RD_NOWE == 0 || w_rd != 5'd0);
        end
    end

    // Handshake: a transfer happens on a cycle where valid && ready at the rising edge;
    // flush (and rst) override both sides, so nothing transfers while they are high.
    state_t r_state, w_state_nxt;
    entry_t r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic   r_alive, r_in_ready;
    logic   w_push, w_pop;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_head_nxt  = w_dec;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_nxt = w_dec;
                    end else if (w_push) begin
                        w_tail_nxt  = w_dec;
                        w_state_nxt = ST_FULL;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_head_nxt  = r_tail;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_EMPTY;
            r_head         <= '0;
            r_head.alucode <= ALU_NOP;
            r_tail         <= '0;
            r_alive        <= 1'b0;
            r_in_ready     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_alive    <= 1'b1;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // A single-entry buffer can only accept when the slot is free or draining this cycle.
    assign in_ready    = (BUF_DEPTH == 2) ? r_in_ready
                                          : (r_alive && (r_state == ST_EMPTY || out_ready));
    assign out_valid   = (r_state != ST_EMPTY);
    assign o_dbg_count = r_state;

    assign out_pc      = r_head.pc;
    assign srcreg1_num = r_head.src1;
    assign srcreg2_num = r_head.src2;
    assign dstreg_num  = r_head.dst;
    assign imm         = r_head.imm;
    assign alucode     = r_head.alucode;
    assign aluop1_type = r_head.op1_type;
    assign aluop2_type = r_head.op2_type;
    assign reg_we      = r_head.reg_we;
    assign is_load     = r_head.is_load;
    assign is_store    = r_head.is_store;
    assign illegal     = r_head.illegal;

endmodule
